// File: rtl/util_axis_uart_tx_cfg.sv
// AXI-Stream UART transmitter with TX FIFO, runtime baud divisor, frame format and break.
// state      | meaning
// S_IDLE     | txd high, waiting for data or a break request
// S_START    | start bit (txd low)
// S_DATA     | data bits, LSB first
// S_PARITY   | optional parity bit
// S_STOP     | one or two stop bits (txd high)
// S_BREAK    | txd held low while brk_req stays high
// S_BRK_MARK | one bit period of mark after a break
module util_axis_uart_tx_cfg #(
  parameter int MAX_DATA_BITS  = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int BAUD_DIV_WIDTH = 16
) (
  input  logic                               aclk,
  input  logic                               rst,
  input  logic [MAX_DATA_BITS-1:0]           s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic [BAUD_DIV_WIDTH-1:0]          cfg_baud_div,
  input  logic [$clog2(MAX_DATA_BITS+1)-1:0] cfg_data_bits,
  input  logic [2:0]                         cfg_parity,
  input  logic                               cfg_stop_bits,
  input  logic                               brk_req,
  output logic                               txd,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);

  localparam int DBW = $clog2(MAX_DATA_BITS+1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_BRK_MARK
  } state_t;

  logic [MAX_DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]             r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]             r_count, w_count_nxt;
  logic                      r_tready;
  logic                      w_push, w_pop, w_empty, w_bit_end;

  state_t                    r_state;
  logic [BAUD_DIV_WIDTH-1:0] r_baud, r_div;
  logic [DBW-1:0]            r_dbits, r_bit_idx, w_eff_dbits;
  logic [MAX_DATA_BITS-1:0]  r_shift, w_head, w_mask;
  logic                      r_par_en, r_par_bit, r_stop2, r_stop_cnt;
  logic                      r_txd, r_busy;
  logic                      w_par_en, w_par_bit, w_data_par;

  assign s_axis_tready = r_tready & ~rst;
  assign w_push        = s_axis_tvalid & s_axis_tready;
  assign w_empty       = (r_count == '0);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_bit_end     = (r_baud == '0);
  // A frame starts from IDLE, or straight out of the last stop bit with no idle gap.
  assign w_pop = !brk_req && !w_empty &&
                 ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end && !r_stop_cnt));

  assign txd        = r_txd;
  assign busy       = r_busy;
  assign fifo_count = r_count;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge aclk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= s_axis_tdata;
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tready <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= w_count_nxt;
      r_tready <= (w_count_nxt != CW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    w_eff_dbits = cfg_data_bits;
    if (cfg_data_bits < DBW'(5) || cfg_data_bits > DBW'(MAX_DATA_BITS))
      w_eff_dbits = DBW'(MAX_DATA_BITS);
    w_mask = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++)
      w_mask[i] = (DBW'(i) < w_eff_dbits);
    w_data_par = ^(w_head & w_mask);
    w_par_en   = 1'b1;
    w_par_bit  = 1'b0;
    case (cfg_parity)
      3'd1:    w_par_bit = w_data_par;
      3'd2:    w_par_bit = ~w_data_par;
      3'd3:    w_par_bit = 1'b1;
      3'd4:    w_par_bit = 1'b0;
      default: w_par_en  = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_baud     <= '0;
      r_div      <= '0;
      r_dbits    <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
    end else if (w_pop) begin
      r_state   <= S_START;
      r_txd     <= 1'b0;
      r_busy    <= 1'b1;
      r_baud    <= cfg_baud_div;
      r_div     <= cfg_baud_div;
      r_dbits   <= w_eff_dbits;
      r_shift   <= w_head;
      r_par_en  <= w_par_en;
      r_par_bit <= w_par_bit;
      r_stop2   <= cfg_stop_bits;
    end else begin
      if (r_state != S_IDLE && r_state != S_BREAK)
        r_baud <= w_bit_end ? r_div : r_baud - 1'b1;
      case (r_state)
        S_IDLE: begin
          if (brk_req) begin
            r_state <= S_BREAK;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_txd     <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= DBW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == r_dbits) begin
              if (r_par_en) begin
                r_state <= S_PARITY;
                r_txd   <= r_par_bit;
              end else begin
                r_state    <= S_STOP;
                r_txd      <= 1'b1;
                r_stop_cnt <= r_stop2;
              end
            end else begin
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state    <= S_STOP;
            r_txd      <= 1'b1;
            r_stop_cnt <= r_stop2;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_stop_cnt) begin
              r_stop_cnt <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_BREAK: begin
          if (!brk_req) begin
            r_state <= S_BRK_MARK;
            r_txd   <= 1'b1;
            r_baud  <= cfg_baud_div;
            r_div   <= cfg_baud_div;
          end
        end
        S_BRK_MARK: begin
          if (w_bit_end) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
